// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end for the single-port RAM.
// Frames are delimited by SS_n (active-low). The first bit after SS_n falls
// selects write (0) or read (1). Reads alternate between "address" and
// "data" frames, tracked by rd_addr_seen. Every frame then shifts in a
// (ADDR_SIZE+2)-bit command word MSB-first and presents it with a one-cycle
// rx_valid strobe. Read-data frames then wait for the RAM's tx_valid and
// serialise the returned byte MSB-first on MISO.
module spi_slave_ctrl #(
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 SS_n,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic [ADDR_SIZE+1:0] rx_data,
   output logic                 rx_valid,
   input  logic [ADDR_SIZE-1:0] tx_data,
   input  logic                 tx_valid
);

   localparam int WORD_W = ADDR_SIZE + 2;
   localparam int BCNT_W = $clog2(WORD_W);
   localparam int TCNT_W = $clog2(ADDR_SIZE);

   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);
   localparam logic [TCNT_W-1:0] LAST_TX  = TCNT_W'(ADDR_SIZE - 1);

   // Frame-level states
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_CHK_CMD   = 3'd1;
   localparam logic [2:0] ST_WRITE     = 3'd2;
   localparam logic [2:0] ST_READ_ADD  = 3'd3;
   localparam logic [2:0] ST_READ_DATA = 3'd4;

   // Progress inside a command state: receiving the word, waiting for the
   // RAM's response, shifting the response out, or idling until SS_n rises.
   localparam logic [1:0] PH_RX   = 2'd0;
   localparam logic [1:0] PH_WAIT = 2'd1;
   localparam logic [1:0] PH_TX   = 2'd2;
   localparam logic [1:0] PH_HOLD = 2'd3;

   logic [2:0]           state_q, state_d;
   logic [1:0]           phase_q, phase_d;
   logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0]    shift_q, shift_d;
   logic [WORD_W-1:0]    rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 rd_addr_seen_q, rd_addr_seen_d;
   logic [ADDR_SIZE-1:0] tx_shift_q, tx_shift_d;
   logic [TCNT_W-1:0]    tx_cnt_q, tx_cnt_d;
   logic                 miso_q, miso_d;

   assign MISO     = miso_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

   // Next-state logic: frame FSM, word deserialiser and read-byte serialiser
   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      bit_cnt_d      = bit_cnt_q;
      shift_d        = shift_q;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      rd_addr_seen_d = rd_addr_seen_q;
      tx_shift_d     = tx_shift_q;
      tx_cnt_d       = tx_cnt_q;
      miso_d         = 1'b0;

      if (SS_n) begin
         // Frame ended (or never started): drop any partial word silently.
         // rd_addr_seen is deliberately left alone so an aborted read-data
         // frame can be retried.
         state_d   = ST_IDLE;
         phase_d   = PH_RX;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d   = ST_CHK_CMD;
               phase_d   = PH_RX;
               bit_cnt_d = '0;
            end
            ST_CHK_CMD: begin
               if (!MOSI)
                  state_d = ST_WRITE;
               else if (rd_addr_seen_q)
                  state_d = ST_READ_DATA;
               else
                  state_d = ST_READ_ADD;
            end
            ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
               case (phase_q)
                  PH_RX: begin
                     shift_d = {shift_q[WORD_W-2:0], MOSI};
                     if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = {shift_q[WORD_W-2:0], MOSI};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        if (state_q == ST_READ_ADD) begin
                           rd_addr_seen_d = 1'b1;
                           phase_d        = PH_HOLD;
                        end else if (state_q == ST_READ_DATA) begin
                           rd_addr_seen_d = 1'b0;
                           phase_d        = PH_WAIT;
                        end else begin
                           phase_d = PH_HOLD;
                        end
                     end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                     end
                  end
                  PH_WAIT: begin
                     // MSB goes out on the same edge the byte is captured
                     if (tx_valid) begin
                        miso_d     = tx_data[ADDR_SIZE-1];
                        tx_shift_d = {tx_data[ADDR_SIZE-2:0], 1'b0};
                        tx_cnt_d   = LAST_TX;
                        phase_d    = PH_TX;
                     end
                  end
                  PH_TX: begin
                     if (tx_cnt_q == '0) begin
                        phase_d = PH_HOLD;
                     end else begin
                        miso_d     = tx_shift_q[ADDR_SIZE-1];
                        tx_shift_d = {tx_shift_q[ADDR_SIZE-2:0], 1'b0};
                        tx_cnt_d   = tx_cnt_q - 1'b1;
                     end
                  end
                  default: begin
                     phase_d = PH_HOLD;
                  end
               endcase
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         phase_q        <= PH_RX;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         rd_addr_seen_q <= 1'b0;
         tx_shift_q     <= '0;
         tx_cnt_q       <= '0;
         miso_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         rd_addr_seen_q <= rd_addr_seen_d;
         tx_shift_q     <= tx_shift_d;
         tx_cnt_q       <= tx_cnt_d;
         miso_q         <= miso_d;
      end
   end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed testbench for spi_slave_ctrl: drives SPI frames bit by bit and
// checks strobes, captured command words and the MISO byte stream.
module tb_spi_slave_ctrl;

   logic       clk;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   int total = 0;
   int bad   = 0;

   // observations gathered while a frame is driven
   int         pulses;
   int         pulse_bit;
   logic [9:0] cap;
   int         miso_ones;

   spi_slave_ctrl #(.ADDR_SIZE(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int idx);
      if (rx_valid === 1'b1) begin
         pulses    = pulses + 1;
         pulse_bit = idx;
         cap       = rx_data;
      end
      if (MISO !== 1'b0) miso_ones = miso_ones + 1;
   endtask

   // SS_n low, decision bit, then nbits of word MSB-first; SS_n stays low
   task automatic drive_frame(input bit dec, input logic [9:0] word, input int nbits);
      pulses    = 0;
      pulse_bit = -1;
      cap       = '0;
      miso_ones = 0;
      SS_n = 1'b0;
      tick();
      sample(-1);
      MOSI = dec;
      tick();
      sample(0);
      for (int i = 0; i < nbits; i++) begin
         MOSI = word[9-i];
         tick();
         sample(i + 1);
      end
   endtask

   task automatic end_frame();
      SS_n = 1'b1;
      MOSI = 1'b0;
      tick();
      sample(99);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      SS_n  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         MOSI = i[0];
         tick();
      end
      total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rst_miso: got %b want 0", MISO); end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
      total++; if (rx_data !== 10'h000) begin bad++; $display("FAIL rst_rx_data: got %h want 000", rx_data); end
      rst_n = 1'b1;
      SS_n  = 1'b1;
      MOSI  = 1'b0;
      tick();
      drive_frame(1'b0, 10'h155, 10);
      total++; if (pulses !== 1) begin bad++; $display("FAIL rst_first_pulses: got %0d want 1", pulses); end
      total++; if (cap !== 10'h155) begin bad++; $display("FAIL rst_first_data: got %h want 155", cap); end
      end_frame();
   endtask

   task automatic test_write();
      logic [9:0] words [2];
      words[0] = 10'h0A5;
      words[1] = 10'h13C;
      for (int f = 0; f < 2; f++) begin
         drive_frame(1'b0, words[f], 10);
         total++; if (pulse_bit !== 10) begin bad++; $display("FAIL wr%0d_strobe_bit: got %0d want 10", f, pulse_bit); end
         total++; if (cap !== words[f]) begin bad++; $display("FAIL wr%0d_data: got %h want %h", f, cap, words[f]); end
         tick();
         sample(11);
         total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL wr%0d_pulse_len: got %b want 0", f, rx_valid); end
         end_frame();
         total++; if (pulses !== 1) begin bad++; $display("FAIL wr%0d_pulses: got %0d want 1", f, pulses); end
         total++; if (miso_ones !== 0) begin bad++; $display("FAIL wr%0d_miso: got %0d ones want 0", f, miso_ones); end
      end
   endtask

   task automatic test_read();
      logic [7:0] rbyte;
      rbyte = 8'h3C;
      // address frame: READ_ADD ignores tx_valid
      drive_frame(1'b1, 10'h2A5, 10);
      total++; if (cap !== 10'h2A5) begin bad++; $display("FAIL rd_addr_data: got %h want 2A5", cap); end
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rd_addr_miso: got %b want 0", MISO); end
      end
      tx_valid = 1'b0;
      end_frame();
      // data frame
      drive_frame(1'b1, 10'h300, 10);
      total++; if (cap !== 10'h300) begin bad++; $display("FAIL rd_data_word: got %h want 300", cap); end
      total++; if (pulse_bit !== 10) begin bad++; $display("FAIL rd_data_strobe_bit: got %0d want 10", pulse_bit); end
      tick();                               // E12: RAM registers the request
      total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rd_pre_miso: got %b want 0", MISO); end
      tx_valid = 1'b1;
      tx_data  = rbyte;
      tick();                               // E13: byte captured, bit7 out
      tx_valid = 1'b0;
      tx_data  = 8'hC3;                     // must not leak into the stream
      for (int k = 7; k >= 0; k--) begin
         total++; if (MISO !== rbyte[k]) begin bad++; $display("FAIL rd_miso_bit%0d: got %b want %b", k, MISO, rbyte[k]); end
         if (k > 0) tick();
      end
      tick();
      total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rd_post_miso: got %b want 0", MISO); end
      // spurious tx_valid after the byte was sent
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rd_spurious_miso: got %b want 0", MISO); end
      end
      tx_valid = 1'b0;
      end_frame();
   endtask

   task automatic test_abort();
      drive_frame(1'b0, 10'h3FF, 6);
      end_frame();
      total++; if (pulses !== 0) begin bad++; $display("FAIL abort_pulses: got %0d want 0", pulses); end
      drive_frame(1'b0, 10'h0F0, 10);
      total++; if (cap !== 10'h0F0) begin bad++; $display("FAIL abort_next_data: got %h want 0F0", cap); end
      end_frame();
      total++; if (pulses !== 1) begin bad++; $display("FAIL abort_next_pulses: got %0d want 1", pulses); end
      // aborted read-data frame keeps rd_addr_seen set
      drive_frame(1'b1, 10'h211, 10);       // READ_ADD
      end_frame();
      drive_frame(1'b1, 10'h3AA, 4);        // READ_DATA, aborted
      end_frame();
      total++; if (pulses !== 0) begin bad++; $display("FAIL abort_rd_pulses: got %0d want 0", pulses); end
      drive_frame(1'b1, 10'h355, 10);       // still READ_DATA
      tx_valid = 1'b1;
      tx_data  = 8'h81;
      tick();
      tx_valid = 1'b0;
      total++; if (MISO !== 1'b1) begin bad++; $display("FAIL abort_rd_retry_miso: got %b want 1", MISO); end
      end_frame();
   endtask

   task automatic test_rd_toggle();
      drive_frame(1'b1, 10'h2A5, 10);       // READ_ADD
      end_frame();
      drive_frame(1'b1, 10'h300, 10);       // READ_DATA, clears flag
      end_frame();
      drive_frame(1'b1, 10'h2AA, 10);       // READ_ADD again
      total++; if (cap !== 10'h2AA) begin bad++; $display("FAIL tog_third_data: got %h want 2AA", cap); end
      tx_valid = 1'b1;
      tx_data  = 8'h81;
      tick();
      tx_valid = 1'b0;
      total++; if (MISO !== 1'b0) begin bad++; $display("FAIL tog_third_miso: got %b want 0", MISO); end
      end_frame();
      total++; if (pulses !== 1) begin bad++; $display("FAIL tog_third_pulses: got %0d want 1", pulses); end
      drive_frame(1'b1, 10'h301, 10);       // READ_DATA again
      tx_valid = 1'b1;
      tx_data  = 8'h81;
      tick();
      tx_valid = 1'b0;
      total++; if (MISO !== 1'b1) begin bad++; $display("FAIL tog_fourth_miso: got %b want 1", MISO); end
      end_frame();
   endtask

   task automatic test_spurious_write();
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      drive_frame(1'b0, 10'h1E1, 10);
      tick();
      sample(11);
      end_frame();
      tx_valid = 1'b0;
      total++; if (miso_ones !== 0) begin bad++; $display("FAIL spw_miso: got %0d ones want 0", miso_ones); end
      total++; if (cap !== 10'h1E1) begin bad++; $display("FAIL spw_data: got %h want 1E1", cap); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL spw_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_reset_midframe();
      drive_frame(1'b1, 10'h2C3, 10);       // READ_ADD
      end_frame();
      drive_frame(1'b1, 10'h3C3, 10);       // READ_DATA
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      tick();
      tx_valid = 1'b0;
      tick();
      total++; if (MISO !== 1'b1) begin bad++; $display("FAIL rstm_shifting: got %b want 1", MISO); end
      rst_n = 1'b0;
      tick();
      total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rstm_miso: got %b want 0", MISO); end
      total++; if (rx_data !== 10'h000) begin bad++; $display("FAIL rstm_rx_data: got %h want 000", rx_data); end
      rst_n = 1'b1;
      SS_n  = 1'b1;
      tick();
      // partial frame then reset: no strobe
      drive_frame(1'b0, 10'h3FF, 5);
      rst_n = 1'b0;
      MOSI  = 1'b1;
      tick();
      sample(50);
      rst_n = 1'b1;
      end_frame();
      total++; if (pulses !== 0) begin bad++; $display("FAIL rstm_partial_pulses: got %0d want 0", pulses); end
      // reset cleared rd_addr_seen: decision 1 is READ_ADD
      drive_frame(1'b1, 10'h2F0, 10);
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      tick();
      tx_valid = 1'b0;
      total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rstm_flag_cleared: got %b want 0", MISO); end
      end_frame();
   endtask

   initial begin
      rst_n    = 1'b0;
      SS_n     = 1'b1;
      MOSI     = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_rd_toggle();
      test_spurious_write();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
